// File: rtl/fifo_rd_serializer.sv
// Drains wide words from the synchronous FIFO and replays them as narrow
// valid/ready beats, least-significant slice first, counting whole words emitted.
module fifo_rd_serializer #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 srst_i,
  input  logic                 fifo_mty_i,
  output logic                 fifo_rd_o,
  input  logic [IN_WIDTH-1:0]  fifo_q_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic                 out_last_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] word_cnt_o
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

  state_t               state_q, state_d;
  logic [IN_WIDTH-1:0]  shreg_q, shreg_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 rd;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new read is only issued from IDLE or on the final beat's handshake, so at
  // most one word is ever in flight between the FIFO and the shift register.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    rd      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_mty_i) begin
          rd      = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        shreg_d = fifo_q_i;
        beat_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (out_ready_i) begin
          shreg_d = shreg_q >> OUT_WIDTH;
          beat_d  = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            cnt_d  = cnt_q + 1'b1;
            beat_d = '0;
            if (!fifo_mty_i) begin
              rd      = 1'b1;
              state_d = S_WAIT;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (srst_i) begin
      state_d = S_IDLE;
      shreg_d = '0;
      beat_d  = '0;
      cnt_d   = '0;
      rd      = 1'b0;
    end
  end

  assign fifo_rd_o   = rd & ~arst;
  assign out_valid_o = (state_q == S_SEND);
  assign out_data_o  = (state_q == S_SEND) ? shreg_q[OUT_WIDTH-1:0] : '0;
  assign out_last_o  = (state_q == S_SEND) && (beat_q == LAST_BEAT);
  assign busy_o      = (state_q != S_IDLE);
  assign word_cnt_o  = cnt_q;

endmodule
